serial_host: RTL and testbench

- Host-side end of the microcontroller's 8N1 serial link.
- Takes a 3-byte command frame from a parallel request port and serialises it onto TXD, which drives the controller's RXD. Then deserialises a 2-byte response from the controller's TXD on its own RXD.
- Used as the link master on board-level test harnesses and in the system bench. Half-duplex, one transaction in flight.

---
 rtl/serial_host.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_serial_host.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_host.sv
// -----------------------------------------------------------------------------
// serial_host
//
// Host-side master of an 8N1 serial link. A 3-byte command from the parallel
// request port is shifted out on TXD, byte0 first, each byte LSB first. The
// block then listens on RXD for a 2-byte response, with a per-byte start-bit
// timeout. Half-duplex: one transaction in flight at a time.
//
// Parameters
//   FREQ_CLK      clock frequency in Hz
//   TX_SPEED      baud rate in bit/s; FREQ_CLK/TX_SPEED must be >= 4
//   TIMEOUT_BITS  bit periods to wait for each response start bit
//
// Ports
//   Clk        system clock
//   Rst_n      asynchronous active-low reset
//   Cmd_Valid  command request
//   Cmd_Data   24-bit command, [7:0] transmitted first
//   Cmd_Ready  high while idle and able to accept a command
//   TXD        serial out, idle high
//   RXD        serial in, asynchronous, idle high
//   Rsp_Valid  one-cycle pulse marking the end of a transaction
//   Rsp_Data   16-bit response, first byte received in [7:0]
//   Rsp_Err    00 ok, 01 timeout, 10 framing error (valid with Rsp_Valid)
// -----------------------------------------------------------------------------
module serial_host #(
  parameter logic [31:0] FREQ_CLK     = 32'd100000000,
  parameter logic [31:0] TX_SPEED     = 32'd115200,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Cmd_Valid,
  input  logic [23:0] Cmd_Data,
  output logic        Cmd_Ready,
  output logic        TXD,
  input  logic        RXD,
  output logic        Rsp_Valid,
  output logic [15:0] Rsp_Data,
  output logic [1:0]  Rsp_Err
);

  localparam int unsigned BIT_CNT = FREQ_CLK / TX_SPEED;
  localparam int unsigned CNT_W   = $clog2(BIT_CNT);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_BITS + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BIT_CNT / 2);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_RX_WAIT,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_FRAME   = 2'b10
  } err_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_byte_idx;
  logic             r_rx_idx;
  logic [TMO_W-1:0] r_tmo;
  logic [23:0]      r_tx_shift;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_rx_lo;
  logic [2:0]       r_rxd_sync;
  logic             r_txd;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_data;
  err_t             r_rsp_err;

  logic w_rxd;
  logic w_rxd_fall;
  logic w_baud_end;
  logic w_baud_half;

  // Two flops resolve metastability; the third only remembers the previous
  // synchronised level for falling-edge detection.
  // NOTE: the synchroniser resets to 1 (line idle) so leaving reset never
  // looks like a start bit.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rxd_sync <= 3'b111;
    end else begin
      r_rxd_sync <= {r_rxd_sync[1:0], RXD};
    end
  end

  assign w_rxd       = r_rxd_sync[1];
  assign w_rxd_fall  = r_rxd_sync[2] & ~r_rxd_sync[1];
  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign w_baud_half = (r_baud == BAUD_HALF);

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments only, so every register sees pre-edge values of the others.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_rx_idx    <= 1'b0;
      r_tmo       <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_lo     <= '0;
      r_txd       <= 1'b1;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      r_rsp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_txd  <= 1'b1;
          r_baud <= '0;
          if (Cmd_Valid && r_cmd_ready) begin
            r_tx_shift  <= Cmd_Data;
            r_byte_idx  <= '0;
            r_cmd_ready <= 1'b0;
            r_txd       <= 1'b0;
            r_state     <= S_TX_START;
          end
        end

        S_TX_START: begin
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_txd     <= r_tx_shift[0];
            r_state   <= S_TX_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // The command register shifts right once per data bit, so after
        // eight bits the next byte is already sitting in [7:0].
        S_TX_DATA: begin
          if (w_baud_end) begin
            r_baud     <= '0;
            r_tx_shift <= r_tx_shift >> 1;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_TX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_tx_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_TX_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_byte_idx != 2'd2) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_txd      <= 1'b0;
              r_state    <= S_TX_START;
            end else begin
              r_rx_idx <= 1'b0;
              r_tmo    <= '0;
              r_state  <= S_RX_WAIT;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // The baud counter doubles as the bit-period timer for the timeout.
        S_RX_WAIT: begin
          if (w_rxd_fall) begin
            r_baud  <= '0;
            r_state <= S_RX_START;
          end else if (w_baud_end) begin
            r_baud <= '0;
            if (r_tmo == TMO_LAST) begin
              r_rsp_err   <= ERR_TIMEOUT;
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // A line that is high again at mid-start was a glitch; the timeout
        // count is deliberately kept so glitches cannot extend the wait.
        S_RX_START: begin
          if (w_baud_half) begin
            r_baud <= '0;
            if (w_rxd) begin
              r_state <= S_RX_WAIT;
            end else begin
              r_bit_idx <= '0;
              r_state   <= S_RX_DATA;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_RX_DATA: begin
          if (w_baud_end) begin
            r_baud     <= '0;
            r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // The first byte is staged and Rsp_Data is only written when the
        // whole response arrives, so it holds its previous value on errors.
        S_RX_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (!w_rxd) begin
              r_rsp_err   <= ERR_FRAME;
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (!r_rx_idx) begin
              r_rx_lo  <= r_rx_shift;
              r_rx_idx <= 1'b1;
              r_tmo    <= '0;
              r_state  <= S_RX_WAIT;
            end else begin
              r_rsp_data  <= {r_rx_shift, r_rx_lo};
              r_rsp_err   <= ERR_OK;
              r_rsp_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // Rsp_Valid is high for this one cycle; Cmd_Ready returns in IDLE,
        // which guarantees at least one idle cycle between transactions.
        S_DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign TXD       = r_txd;
  assign Cmd_Ready = r_cmd_ready;
  assign Rsp_Valid = r_rsp_valid;
  assign Rsp_Data  = r_rsp_data;
  assign Rsp_Err   = r_rsp_err;

endmodule

// File: tb/tb_serial_host.sv
// -----------------------------------------------------------------------------
// tb_serial_host
//
// Bench for serial_host at BIT_CNT = 1600/100 = 16 and TIMEOUT_BITS = 8.
// Stimulus pushes the expected TX bytes and responses into queues; a TXD
// decoder and a response monitor pop and compare independently.
// -----------------------------------------------------------------------------
module tb_serial_host;

  localparam int BIT = 16;
  localparam longint PER = 10;
  localparam longint REPLY_OFS = (30 * BIT + 2 * BIT) * PER;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [23:0] cmd_data;
  logic        cmd_ready;
  logic        txd;
  logic        rxd;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_err;

  serial_host #(
    .FREQ_CLK    (32'd1600),
    .TX_SPEED    (32'd100),
    .TIMEOUT_BITS(8)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Cmd_Valid(cmd_valid),
    .Cmd_Data (cmd_data),
    .Cmd_Ready(cmd_ready),
    .TXD      (txd),
    .RXD      (rxd),
    .Rsp_Valid(rsp_valid),
    .Rsp_Data (rsp_data),
    .Rsp_Err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  err;
    bit          chk_data;
    longint      t_ref;
    longint      t_exp;
    longint      tol;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [7:0] tx_q[$];

  int     n_checks  = 0;
  int     n_errors  = 0;
  int     rsp_cnt   = 0;
  int     acc_cnt   = 0;
  longint acc_t     = 0;
  longint last_rsp_t = 0;
  bit     tx_check_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic exp_rsp(input logic [15:0] d, input logic [1:0] e, input bit cd,
                         input longint tr, input longint te, input longint tol);
    rsp_t r;
    r.data = d; r.err = e; r.chk_data = cd; r.t_ref = tr; r.t_exp = te; r.tol = tol;
    rsp_q.push_back(r);
  endtask

  task automatic push_cmd_bytes(input logic [23:0] d);
    tx_q.push_back(d[7:0]);
    tx_q.push_back(d[15:8]);
    tx_q.push_back(d[23:16]);
  endtask

  // Accept happens on the posedge after a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      acc_t = $time + 5;
      acc_cnt++;
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        rsp_cnt++;
        last_rsp_t = $time;
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: data=%0h err=%0h (t=%0t)", rsp_data, rsp_err, $time);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_err", rsp_err, e.err);
          if (e.chk_data) check("rsp_data", rsp_data, e.data);
          if (e.tol > 0)
            check_range("rsp_latency", $time - e.t_ref, e.t_exp - e.tol, e.t_exp + e.tol);
          @(negedge clk);
          check("rsp_pulse_one_cycle", rsp_valid, 1'b0);
          check("ready_after_rsp", cmd_ready, 1'b1);
        end
      end
    end
  end

  // TXD decoder: samples mid-bit, 16 cycles apart.
  initial begin
    logic [7:0] b;
    logic       s;
    logic       p;
    forever begin
      @(negedge clk);
      if (rst_n && txd == 1'b0) begin
        repeat (7) @(negedge clk);
        s = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        p = txd;
        if (tx_check_en) begin
          if (tx_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_tx_byte: got %0h", b);
          end else begin
            check("tx_start_bit", s, 1'b0);
            check("tx_byte", b, tx_q.pop_front());
            check("tx_stop_bit", p, 1'b1);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input longint t);
    while ($time < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [23:0] d, input bit hold, output longint t_acc);
    int base;
    base      = acc_cnt;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && acc_cnt == base; i++) begin
      @(posedge clk);
      #1;
    end
    if (acc_cnt == base) fail_now("cmd_accept");
    t_acc = (acc_cnt == base) ? $time : acc_t;
    if (!hold) cmd_valid = 1'b0;
    @(negedge clk);
    check("ready_low_after_accept", cmd_ready, 1'b0);
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(BIT);
    end
    rxd = stop;
    tick(BIT);
    rxd = 1'b1;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < n && rsp_q.size() != 0; i++) @(posedge clk);
    if (rsp_q.size() != 0) begin
      fail_now("rsp_wait");
      rsp_q.delete();
    end
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint ta;
    longint ta2;
    int     base;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    rxd       = 1'b1;

    // Reset with RXD toggling.
    for (int i = 0; i < 20; i++) begin
      rxd = ~rxd;
      tick(1);
    end
    rxd = 1'b1;
    check("reset_txd", txd, 1'b1);
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_data", rsp_data, 16'h0000);
    check("reset_rsp_err", rsp_err, 2'b00);
    rst_n = 1'b1;
    tick(100);
    check("idle_txd", txd, 1'b1);
    check("idle_ready", cmd_ready, 1'b1);
    check("idle_no_rsp", rsp_cnt, 0);

    // Basic transaction.
    push_cmd_bytes(24'hC3A501);
    issue(24'hC3A501, 1'b0, ta);
    exp_rsp(16'h0F5A, 2'b00, 1'b1, 0, 0, 0);
    tick(240);
    check("ready_low_mid_tx", cmd_ready, 1'b0);
    wait_until(ta + REPLY_OFS);
    check("ready_low_rx_wait", cmd_ready, 1'b0);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_rsp(300);

    // Timeout: 480 TX cycles + 8*16 wait, seen at the following negedge.
    push_cmd_bytes(24'h123456);
    issue(24'h123456, 1'b0, ta);
    exp_rsp(16'h0F5A, 2'b01, 1'b1, ta, (30 * BIT + 8 * BIT) * PER + 5, BIT * PER);
    wait_rsp(1000);

    // Framing error on the first response byte.
    push_cmd_bytes(24'h00AA55);
    issue(24'h00AA55, 1'b0, ta);
    exp_rsp(16'h0000, 2'b10, 1'b0, 0, 0, 0);
    wait_until(ta + REPLY_OFS);
    send_byte(8'h33, 1'b0);
    wait_rsp(300);

    // Glitch rejection followed by a valid reply.
    push_cmd_bytes(24'hF00F5A);
    issue(24'hF00F5A, 1'b0, ta);
    exp_rsp(16'h81C6, 2'b00, 1'b1, 0, 0, 0);
    wait_until(ta + REPLY_OFS);
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(2 * BIT);
    send_byte(8'hC6, 1'b1);
    send_byte(8'h81, 1'b1);
    wait_rsp(300);

    // Mid-frame reset during byte1 data bits (byte1 = 00, so TXD is low).
    tx_check_en = 1'b0;
    issue(24'hFF00FF, 1'b0, ta);
    wait_until(ta + 200 * PER);
    #2;
    check("txd_low_before_reset", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("txd_high_on_reset", txd, 1'b1);
    check("ready_on_reset", cmd_ready, 1'b1);
    check("rsp_data_on_reset", rsp_data, 16'h0000);
    tick(5);
    rst_n = 1'b1;
    tick(300);
    tx_check_en = 1'b1;
    push_cmd_bytes(24'h000000);
    issue(24'h000000, 1'b0, ta);
    exp_rsp(16'h3412, 2'b00, 1'b1, 0, 0, 0);
    wait_until(ta + REPLY_OFS);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_rsp(300);

    // Back-to-back with Cmd_Valid held high.
    push_cmd_bytes(24'h030201);
    push_cmd_bytes(24'h0C0B0A);
    issue(24'h030201, 1'b1, ta);
    base     = acc_cnt;
    cmd_data = 24'h0C0B0A;
    exp_rsp(16'h2211, 2'b00, 1'b1, 0, 0, 0);
    exp_rsp(16'hEE77, 2'b00, 1'b1, 0, 0, 0);
    wait_until(ta + REPLY_OFS);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    for (int i = 0; i < 100 && acc_cnt == base; i++) tick(1);
    if (acc_cnt == base) begin
      fail_now("b2b_second_accept");
      ta2 = $time;
    end else begin
      ta2 = acc_t;
      // Rsp_Valid seen at negedge t; IDLE cycle follows; accept edge at t+15.
      check("b2b_accept_gap_ns", 32'(ta2 - last_rsp_t), 32'd15);
    end
    cmd_valid = 1'b0;
    wait_until(ta2 + 200 * PER);
    for (int i = 0; i < 180; i++) begin
      rxd = 1'($urandom);
      tick(1);
    end
    rxd = 1'b1;
    check("rsp_data_hold_in_tx", rsp_data, 16'h2211);
    check("rsp_err_hold_in_tx", rsp_err, 2'b00);
    wait_until(ta2 + REPLY_OFS);
    send_byte(8'h77, 1'b1);
    send_byte(8'hEE, 1'b1);
    wait_rsp(300);

    tick(50);
    check("tx_queue_drained", tx_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
